// File: rtl/sample_uart_tx.sv
// Sample FIFO feeding an 8N1 UART transmitter with a registered tx line and a sticky overflow flag.
// Optional: define UART_TX_PARITY_EN to append an even-parity bit (8E1, 11-bit frame).
module sample_uart_tx #(
   parameter int BAUD_DIV   = 868,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [7:0]                    sample_in,
   input  logic                          sample_valid,
   output logic                          sample_ready,
   output logic                          tx,
   output logic                          busy,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(BAUD_DIV);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t          state, state_d;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [LW-1:0]   level;
   logic [CW-1:0]   cnt;
   logic [2:0]      idx;
   logic [7:0]      shift, shift_d;
   logic            tx_d, full, push, pop, bit_done;
`ifdef UART_TX_PARITY_EN
   logic            par;
`endif

   // Ready comes only from the registered level, so a same-edge pop never frees a slot.
   assign full         = (level == LW'(FIFO_DEPTH));
   assign sample_ready = !full;
   assign push         = sample_valid && !full;
   assign pop          = (state == IDLE) && (level != '0);
   assign bit_done     = (cnt == CW'(BAUD_DIV - 1));
   assign fifo_level   = level;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= sample_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
         if (sample_valid && full) overflow <= 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state;
      case (state)
         IDLE:  if (level != '0) state_d = START;
         START: if (bit_done) state_d = DATA;
`ifdef UART_TX_PARITY_EN
         DATA:   if (bit_done && idx == 3'd7) state_d = PARITY;
         PARITY: if (bit_done) state_d = STOP;
`else
         DATA:  if (bit_done && idx == 3'd7) state_d = STOP;
`endif
         STOP:  if (bit_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic: tx is computed for the upcoming state and registered below.
   always_comb begin
      shift_d = shift;
      if (pop)                           shift_d = mem[rd_ptr];
      else if (state == DATA && bit_done) shift_d = shift >> 1;
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_d = par;
`endif
         default: tx_d = 1'b1;
      endcase
      busy = (state != IDLE) || (level != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         idx   <= '0;
         shift <= '0;
         tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par   <= 1'b0;
`endif
      end else begin
         shift <= shift_d;
         tx    <= tx_d;
         if (pop) begin
            cnt <= '0;
            idx <= '0;
`ifdef UART_TX_PARITY_EN
            par <= ^mem[rd_ptr];
`endif
         end else if (state != IDLE) begin
            if (bit_done) begin
               cnt <= '0;
               if (state == DATA) idx <= idx + 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sample_uart_tx.sv
// Bench for sample_uart_tx: every cycle compares all outputs against a queue + frame-timer model.
module tb_sample_uart_tx;

   localparam int BAUD  = 4;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * BAUD;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] sample_in;
   logic       sample_valid;
   logic       sample_ready, tx, busy, overflow;
   logic [2:0] fifo_level;

   int tests = 0;
   int fails = 0;

   logic [7:0]  q[$];
   int          m_timer;
   logic [10:0] m_bits;
   logic        m_ovf;
   int          peak;

   sample_uart_tx #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
      .sample_ready(sample_ready), .tx(tx), .busy(busy), .overflow(overflow),
      .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   function automatic logic [10:0] frame_bits(input logic [7:0] d);
      logic [10:0] b;
      b      = '1;
      b[0]   = 1'b0;
      b[8:1] = d;
`ifdef UART_TX_PARITY_EN
      b[9]   = ^d;
`endif
      return b;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_timer = 0;
      m_bits  = '1;
      m_ovf   = 1'b0;
   endtask

   // One clock: queue occupancy and frame timing are decided from pre-edge model state.
   task automatic model_edge(input logic v, input logic [7:0] d);
      int sz;
      sz = q.size();
      if (m_timer == 0 && sz > 0) begin
         m_bits  = frame_bits(q.pop_front());
         m_timer = FRAME;
      end else if (m_timer > 0) begin
         m_timer--;
      end
      if (v) begin
         if (sz < DEPTH) q.push_back(d);
         else            m_ovf = 1'b1;
      end
   endtask

   task automatic check_all();
      logic exp_tx;
      exp_tx = (m_timer == 0) ? 1'b1 : m_bits[(FRAME - m_timer) / BAUD];
      chk("tx", tx, exp_tx);
      chk("level", fifo_level, q.size());
      chk("ready", sample_ready, q.size() < DEPTH);
      chk("busy", busy, (m_timer > 0) || (q.size() > 0));
      chk("overflow", overflow, m_ovf);
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
   endtask

   task automatic cycle(input logic v, input logic [7:0] d);
      sample_valid = v;
      sample_in    = d;
      @(posedge clk);
      model_edge(v, d);
      #1;
      check_all();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((m_timer != 0 || q.size() != 0) && n < 1000) begin
         cycle(1'b0, 8'h00);
         n++;
      end
      chk("drain_bound", n < 1000, 1'b1);
      cycle(1'b0, 8'h00);
   endtask

   task automatic async_reset();
      #1 rst_n = 1'b0;
      #1;
      chk("rst_tx", tx, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_level", fifo_level, 3'd0);
      chk("rst_ovf", overflow, 1'b0);
      chk("rst_ready", sample_ready, 1'b1);
      model_reset();
      sample_valid = 1'b0;
      #10 rst_n = 1'b1;
   endtask

   initial begin
      int n;
      sample_valid = 1'b0;
      sample_in    = 8'h00;
      rst_n        = 1'b1;
      peak         = 0;
      model_reset();
      #1 rst_n = 1'b0;
      #1;
      chk("init_tx", tx, 1'b1);
      chk("init_busy", busy, 1'b0);
      chk("init_level", fifo_level, 3'd0);
      chk("init_ovf", overflow, 1'b0);
      chk("init_ready", sample_ready, 1'b1);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // Single frame, then line must be idle and not busy 41 clocks after the push.
      cycle(1'b1, 8'h32);
      cycle(1'b0, 8'h00);
      chk("t1_start", tx, 1'b0);
      for (int i = 0; i < 39; i++) cycle(1'b0, 8'h00);
      chk("t1_busy40", busy, 1'b1);
      cycle(1'b0, 8'h00);
      chk("t1_busy41", busy, 1'b0);
      drain();

      // Back-to-back samples.
      peak = 0;
      cycle(1'b1, 8'h5A);
      cycle(1'b1, 8'hA5);
      cycle(1'b1, 8'hFF);
      cycle(1'b1, 8'h00);
      drain();
      chk("t2_peak", peak, 3);
      chk("t2_ovf", overflow, 1'b0);

      // Hold valid for six samples during a frame.
      cycle(1'b1, 8'($urandom));
      for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00);
      for (int i = 0; i < 6; i++) cycle(1'b1, 8'($urandom));
      chk("t3_ovf", overflow, 1'b1);
      chk("t3_level", fifo_level, 3'd4);
      drain();
      chk("t3_ovf_sticky", overflow, 1'b1);

      // Reset at clock 15 of a frame.
      cycle(1'b1, 8'($urandom));
      for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00);
      cycle(1'b1, 8'($urandom));
      async_reset();
      cycle(1'b1, 8'h0F);
      drain();

      cycle(1'b1, 8'h07);
      drain();
      cycle(1'b1, 8'h03);
      drain();

      // Push refused on the edge where a full FIFO pops.
      cycle(1'b1, 8'($urandom));
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom));
      chk("t6_full", fifo_level, 3'd4);
      n = 0;
      while (m_timer != 0 && n < 200) begin
         cycle(1'b0, 8'h00);
         n++;
      end
      chk("t6_bound", n < 200, 1'b1);
      chk("t6_ovf_pre", overflow, 1'b0);
      cycle(1'b1, 8'h99);
      chk("t6_ovf", overflow, 1'b1);
      chk("t6_level", fifo_level, 3'd3);
      drain();

      // Random traffic, with a mid-stream reset.
      async_reset();
      for (int i = 0; i < 600; i++) cycle(($urandom % 5) == 0, 8'($urandom));
      async_reset();
      for (int i = 0; i < 400; i++) cycle(($urandom % 3) == 0, 8'($urandom));
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
